// File: rtl/eq_cmp_seq_pkg.sv
// Shared types and sizing helpers for the sequential slice comparator.
package eq_cmp_seq_pkg;

    // Controller states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Default geometry.
    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned SLICE_DEF = 2;

    // Number of slices for a given operand width and slice size.
    function automatic int unsigned calc_nsl(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    // Slice index register width; never narrower than one bit.
    function automatic int unsigned calc_idx_w(input int unsigned nsl);
        return (nsl > 1) ? $clog2(nsl) : 1;
    endfunction

    localparam int unsigned NSL_DEF   = calc_nsl(WIDTH_DEF, SLICE_DEF);
    localparam int unsigned IDX_W_DEF = calc_idx_w(NSL_DEF);

endpackage

// File: rtl/eq_cmp_slice.sv
// Unsigned compare of one SLICE-bit operand slice.
module eq_cmp_slice #(
    parameter int unsigned SLICE = 2
) (
    input  logic [SLICE-1:0] sa,
    input  logic [SLICE-1:0] sb,
    output logic             eq,
    output logic             gt
);

    // Pure combinational slice relation.
    always_comb begin
        eq = (sa == sb);
        gt = (sa > sb);
    end

endmodule

// File: rtl/eq_cmp_seq.sv
// Sequential WIDTH-bit comparator: walks SLICE-bit slices MSB first, stops at first difference.
module eq_cmp_seq
    import eq_cmp_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb
);

    localparam int unsigned NSL   = calc_nsl(WIDTH, SLICE);
    localparam int unsigned IDX_W = calc_idx_w(NSL);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSL - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic [WIDTH-1:0]   bias;
    logic               done_q, aeqb_q, agtb_q, altb_q;
    logic [SLICE-1:0]   slice_a, slice_b;
    logic               s_eq, s_gt;
    logic               accept, decide;

    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
    always_comb begin
        bias = '0;
        bias[WIDTH-1] = signed_mode;
    end

    // Select the current slice of each latched operand.
    always_comb begin
        slice_a = opa_q[SLICE*int'(idx_q) +: SLICE];
        slice_b = opb_q[SLICE*int'(idx_q) +: SLICE];
    end

    eq_cmp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .sa (slice_a),
        .sb (slice_b),
        .eq (s_eq),
        .gt (s_gt)
    );

    // Handshake and decision qualifiers; abort suppresses any decision.
    always_comb begin
        accept = (state_q == ST_IDLE) && start;
        decide = (state_q == ST_BUSY) && !abort && (!s_eq || (idx_q == '0));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_BUSY;
            ST_BUSY: if (abort || decide) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and result registers.
    always_comb begin
        ready = (state_q == ST_IDLE);
        done  = done_q;
        aeqb  = aeqb_q;
        agtb  = agtb_q;
        altb  = altb_q;
    end

    // Operand capture and slice index walk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q <= '0;
            opb_q <= '0;
            idx_q <= IDX_TOP;
        end else if (accept) begin
            opa_q <= a ^ bias;
            opb_q <= b ^ bias;
            idx_q <= IDX_TOP;
        end else if ((state_q == ST_BUSY) && !abort && !decide) begin
            idx_q <= idx_q - 1'b1;
        end
    end

    // Result flags and the one-cycle done pulse; flags hold until the next decision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
            aeqb_q <= 1'b1;
            agtb_q <= 1'b0;
            altb_q <= 1'b0;
        end else begin
            done_q <= decide;
            if (decide) begin
                aeqb_q <= s_eq;
                agtb_q <= !s_eq && s_gt;
                altb_q <= !s_eq && !s_gt;
            end
        end
    end

endmodule

// File: tb/tb_eq_cmp_seq.sv
// Self-checking bench for eq_cmp_seq: directed table, multi-cycle corner sequences, param sweep.
module tb_eq_cmp_seq;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance, 16/2.
    logic        start = 0, signed_mode = 0, abort = 0;
    logic [15:0] a = '0, b = '0;
    logic        ready, done, aeqb, agtb, altb;

    eq_cmp_seq #(.WIDTH(16), .SLICE(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(signed_mode), .abort(abort),
        .a(a), .b(b), .ready(ready), .done(done), .aeqb(aeqb), .agtb(agtb), .altb(altb)
    );

    // Sweep instance, 8/8 (single slice).
    logic       s8_start = 0, s8_sm = 0;
    logic [7:0] s8_a = '0, s8_b = '0;
    logic       s8_ready, s8_done, s8_eq, s8_gt, s8_lt;

    eq_cmp_seq #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(s8_start), .signed_mode(s8_sm), .abort(1'b0),
        .a(s8_a), .b(s8_b), .ready(s8_ready), .done(s8_done), .aeqb(s8_eq), .agtb(s8_gt),
        .altb(s8_lt)
    );

    // Sweep instance, 12/3.
    logic        s12_start = 0, s12_sm = 0;
    logic [11:0] s12_a = '0, s12_b = '0;
    logic        s12_ready, s12_done, s12_eq, s12_gt, s12_lt;

    eq_cmp_seq #(.WIDTH(12), .SLICE(3)) dut12 (
        .clk(clk), .reset_n(reset_n), .start(s12_start), .signed_mode(s12_sm), .abort(1'b0),
        .a(s12_a), .b(s12_b), .ready(s12_ready), .done(s12_done), .aeqb(s12_eq),
        .agtb(s12_gt), .altb(s12_lt)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: latency = position of first differing slice from MSB (NSL if equal);
    // flags from an integer compare of the operands as unsigned or signed values.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic sm,
                         input int w, input int s, output int lat, output logic [2:0] f);
        int n, av, bv;
        logic [15:0] diff, mask;
        n = w / s;
        lat = n;
        diff = ma ^ mb;
        mask = 16'((1 << s) - 1);
        for (int k = 1; k <= n; k++) begin
            if (((diff >> ((n - k) * s)) & mask) != 0) begin
                lat = k;
                break;
            end
        end
        av = int'(ma);
        bv = int'(mb);
        if (sm && ma[w-1]) av = av - (1 << w);
        if (sm && mb[w-1]) bv = bv - (1 << w);
        f = {av == bv, av > bv, av < bv};
    endtask

    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic sm);
        a = ta;
        b = tb;
        signed_mode = sm;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    // Count edges until done; ready must stay low while waiting.
    task automatic wait_done(input int limit, output int lat);
        int rdy_bad;
        rdy_bad = 0;
        lat = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (ready) rdy_bad++;
        end
        check("ready_low_while_busy", 32'(rdy_bad), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        int          lat;
        logic [2:0]  flags;  // {aeqb, agtb, altb}
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, elat;
        logic [2:0] ef;
        logic [15:0] av, bv;
        logic sm;

        vecs[0] = '{16'hA5A5, 16'hA5A5, 1'b0, 8, 3'b100};
        vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1, 3'b010};
        vecs[2] = '{16'h8000, 16'h0001, 1'b1, 1, 3'b001};
        vecs[3] = '{16'h0004, 16'h0007, 1'b0, 8, 3'b001};
        vecs[4] = '{16'hFFFF, 16'hFFFE, 1'b1, 8, 3'b010};
        vecs[5] = '{16'h1234, 16'h1244, 1'b0, 5, 3'b001};
        vecs[6] = '{16'h7FFF, 16'h8000, 1'b1, 1, 3'b010};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 8, 3'b100};

        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'({aeqb, agtb, altb}), 32'b100);
        reset_n = 1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sm);
            check($sformatf("vec%0d_ready_after_start", i), 32'(ready), 32'd0);
            wait_done(20, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_flags", i), 32'({aeqb, agtb, altb}), 32'(vecs[i].flags));
            check($sformatf("vec%0d_ready_with_done", i), 32'(ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_one_cycle", i), 32'(done), 32'd0);
        end

        // Back-to-back: start held through the done cycle.
        a = 16'h8000; b = 16'h0001; signed_mode = 0; start = 1;
        @(posedge clk);
        #1;
        a = 16'h0004; b = 16'h0007;
        @(posedge clk);
        #1;
        check("b2b_first_done", 32'(done), 32'd1);
        check("b2b_first_flags", 32'({aeqb, agtb, altb}), 32'b010);
        @(posedge clk);
        #1;
        start = 0;
        check("b2b_no_bubble_ready", 32'(ready), 32'd0);
        wait_done(20, lat);
        check("b2b_second_latency", 32'(lat), 32'd8);
        check("b2b_second_flags", 32'({aeqb, agtb, altb}), 32'b001);

        // Start pulsed mid-BUSY is ignored.
        start_op(16'hA5A5, 16'hA5A5, 1'b0);
        a = 16'h0000; b = 16'hFFFF; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        @(posedge clk);
        #1;
        wait_done(20, lat);
        check("ignored_start_latency", 32'(lat + 2), 32'd8);
        check("ignored_start_flags", 32'({aeqb, agtb, altb}), 32'b100);

        // Abort on the third cycle of an equal compare: flags keep the prior gt result.
        start_op(16'h8000, 16'h0001, 1'b0);
        wait_done(20, lat);
        start_op(16'hA5A5, 16'hA5A5, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1;
        @(posedge clk);
        #1;
        abort = 0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_flags_kept", 32'({aeqb, agtb, altb}), 32'b010);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) lat++;
        end
        check("abort_no_late_done", 32'(lat), 32'd0);

        // Abort on the deciding edge wins over the decision.
        start_op(16'h0004, 16'h0007, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        abort = 1;
        @(posedge clk);
        #1;
        abort = 0;
        check("abort_beats_decide_done", 32'(done), 32'd0);
        check("abort_beats_decide_flags", 32'({aeqb, agtb, altb}), 32'b010);
        check("abort_beats_decide_ready", 32'(ready), 32'd1);

        // start and abort together in IDLE: start wins.
        abort = 1;
        start_op(16'h8000, 16'h0001, 1'b1);
        abort = 0;
        check("idle_abort_start_wins", 32'(ready), 32'd0);
        wait_done(20, lat);
        check("idle_abort_latency", 32'(lat), 32'd1);
        check("idle_abort_flags", 32'({aeqb, agtb, altb}), 32'b001);

        // Asynchronous reset mid-compare.
        start_op(16'hA5A5, 16'hA5A5, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 0;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_flags", 32'({aeqb, agtb, altb}), 32'b100);
        #2;
        reset_n = 1;
        @(posedge clk);
        #1;

        // Sweep 8/8.
        for (int i = 0; i < 24; i++) begin
            av = 16'($urandom_range(0, 255));
            bv = (i % 3 == 0) ? av : 16'($urandom_range(0, 255));
            sm = 1'($urandom_range(0, 1));
            model(av, bv, sm, 8, 8, elat, ef);
            s8_a = av[7:0]; s8_b = bv[7:0]; s8_sm = sm; s8_start = 1;
            @(posedge clk);
            #1;
            s8_start = 0;
            lat = 0;
            for (int k = 1; k <= 6; k++) begin
                @(posedge clk);
                #1;
                if (s8_done) begin
                    lat = k;
                    break;
                end
            end
            check($sformatf("w8_lat a=%0h b=%0h", av, bv), 32'(lat), 32'(elat));
            check($sformatf("w8_flags a=%0h b=%0h s=%0d", av, bv, sm),
                  32'({s8_eq, s8_gt, s8_lt}), 32'(ef));
        end

        // Sweep 12/3, with single-bit flips to spread the deciding slice.
        for (int i = 0; i < 32; i++) begin
            av = 16'($urandom_range(0, 4095));
            bv = (i % 4 == 0) ? av : (av ^ 16'(1 << $urandom_range(0, 11)));
            if (i % 4 == 1) bv = 16'($urandom_range(0, 4095));
            sm = 1'($urandom_range(0, 1));
            model(av, bv, sm, 12, 3, elat, ef);
            s12_a = av[11:0]; s12_b = bv[11:0]; s12_sm = sm; s12_start = 1;
            @(posedge clk);
            #1;
            s12_start = 0;
            lat = 0;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk);
                #1;
                if (s12_done) begin
                    lat = k;
                    break;
                end
            end
            check($sformatf("w12_lat a=%0h b=%0h", av, bv), 32'(lat), 32'(elat));
            check($sformatf("w12_flags a=%0h b=%0h s=%0d", av, bv, sm),
                  32'({s12_eq, s12_gt, s12_lt}), 32'(ef));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
